jtframe_dial_dec: RTL and testbench
===================================

Name: jtframe_dial_dec

Overview:
- Quadrature decoder/counter that consumes the 2-bit dial phases produced by the dial emulation stage (dial_x, dial_y).
- Keeps one signed, wrap-around position counter per axis and presents them to the game CPU through a uPD4701-style byte-read port.
- Read values are snapshotted so each read is coherent. A count-flag tells the CPU that movement occurred.
- Sits between the dial emulation stage and the core's CPU input mux.

Parameters:
- CW, 12, counter width per axis in bits (legal values 9..16).
- SYNC, 2, synchroniser flip-flop stages on the dial inputs (minimum 1).
- INVX, 0, 1 inverts the X count direction.
- INVY, 0, 1 inverts the Y count direction.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- dial_x  in  2  X quadrature phases; bit0=A, bit1=B.
- dial_y  in  2  Y quadrature phases; bit0=A, bit1=B.
- clr_x  in  1  synchronous clear of the X live counter.
- clr_y  in  1  synchronous clear of the Y live counter.
- cs  in  1  CPU read strobe, active-high, level.
- xn_y  in  1  axis select: 0=X, 1=Y.
- uln  in  1  byte select: 0=low byte, 1=high bits.
- dout  out  8  read data, registered.
- cf  out  1  count flag: movement since the last completed read.
- err  out  1  one-cycle pulse on an illegal phase transition (either axis).

Behaviour:
- Reset (rst_n low, asynchronous):
  - live counters, snapshots, synchroniser chains and previous-phase registers go to 0;
  - dout=0, cf=0, err=0.
- Input sync:
  - Each dial bus passes through SYNC flops, then one "previous" register.
  - Decode compares the synchronised phase against the previous one.
- Phase decode (value = {B,A}):
  - Forward sequence 0→1→3→2→0 gives +1.
  - Reverse sequence gives −1.
  - No change gives 0.
  - Both bits changing (0↔3, 1↔2) is illegal: no count, err=1 for that cycle.
  - INVX/INVY swap the sign of ±1.
- Latency: a dial edge updates the live counter SYNC+1 clk cycles after it is applied.
- Counters:
  - CW-bit two's complement, modulo 2^CW. Max+1 wraps to 0x000; 0−1 wraps to all ones.
  - clr_x/clr_y force 0 on the next edge and override a same-cycle count.
- Snapshot:
  - On the cs rising edge (cs=1, cs_l=0), both snapshots load the live counters' pre-update values in that cycle.
  - Live counting continues during cs high; the snapshots stay frozen until the next cs rising edge.
- Read data:
  - While cs=1, dout is registered from the selected snapshot each cycle.
  - uln=0 gives snapshot[7:0].
  - uln=1 gives {sign-extend of snapshot[CW-1], snapshot[CW-1:8]} zero-padded to 8 bits. For CW=12 this is {4{s[11]}, s[11:8]}.
  - With cs=0, dout holds its last value.
  - First valid data appears on the edge after cs rises; the select lines may change during cs and are reflected one cycle later.
- cf:
  - Set by any non-zero count on either axis.
  - Cleared on the cs falling edge.
  - If a count and the clear coincide, set wins and cf stays 1.
  - clr_x/clr_y do not affect cf.
- Simultaneous X and Y events are independent. err is the OR of both axes' illegal detects.
- Reset mid-read: everything returns to its reset value. A cs held high through reset release does not produce a snapshot until cs next rises.

Decomposition:
- Shared package holds:
  - phase-decode constants FWD_NEXT lookup (0→1, 1→3, 3→2, 2→0);
  - the byte-select encodings;
  - the default CW.
- One sub-module, jtframe_dial_axis, instantiated twice. It contains sync chain, previous register, decode, CW counter, clear and invert.
- It outputs the count value, a moved pulse and an illegal pulse.
- The top level holds snapshot, read mux, cf and err.

Test Plan:
- Reset, then apply X phases 0,1,3,2,0 with 4 clk between steps → X counter = 4. cf=1. Read with xn_y=0,uln=0 gives dout=0x04; uln=1 gives 0x00.
- From 0, apply Y phases 0,2,3,1,0 → Y = 0xFFC. Low read gives 0xFC; high read gives 0xFF.
- X at 0xFFF, one forward step → 0x000, no err. Set INVX=1 and repeat the forward step → X = 0xFFF.
- Apply X phase 0→3 directly → err high exactly one cycle, X unchanged, cf unchanged.
- Raise cs, then apply 3 forward X steps while cs stays high → low read remains the pre-cs value. After cs drops and rises again, the read shows +3. cf clears on the cs fall.
- Assert clr_x in the same cycle as a decoded +1 → X=0 and cf=1. Pull rst_n low asynchronously mid-read → dout=0 and cf=0 immediately.

Source files
------------

// File: rtl/jtframe_dial_dec_pkg.sv
// Shared definitions for the dial quadrature decoder.
//   CW_DEF      default counter width per axis
//   byte_sel_e  encoding of the uln byte-select line
//   axis_sel_e  encoding of the xn_y axis-select line
//   fwd_next()  phase that follows p when turning forward ({B,A}: 0->1->3->2->0)
package jtframe_dial_dec_pkg;
  localparam int CW_DEF = 12;

  typedef enum logic { BYTE_LO = 1'b0, BYTE_HI = 1'b1 } byte_sel_e;
  typedef enum logic { AXIS_X  = 1'b0, AXIS_Y  = 1'b1 } axis_sel_e;

  function automatic logic [1:0] fwd_next(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd1;
      2'd1:    return 2'd3;
      2'd3:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/jtframe_dial_dec_if.sv
// CPU-side byte-read port of the dial decoder (uPD4701 style).
//   cs    read strobe, level          xn_y  axis select (0=X, 1=Y)
//   uln   byte select (0=low, 1=high) dout  registered read data
//   cf    count flag
interface jtframe_dial_dec_if;
  logic       cs;
  logic       xn_y;
  logic       uln;
  logic [7:0] dout;
  logic       cf;

  modport master (output cs, xn_y, uln, input  dout, cf);
  modport slave  (input  cs, xn_y, uln, output dout, cf);
endinterface

// File: rtl/jtframe_dial_axis.sv
// One dial axis: input synchroniser, previous-phase register, quadrature
// decode and a CW-bit wrap-around position counter.
//   ph       raw {B,A} phases          clr      synchronous counter clear
//   cnt      live counter              moved    legal non-zero step this cycle
//   illegal  both phase bits changed this cycle
module jtframe_dial_axis
  import jtframe_dial_dec_pkg::*;
#(
  parameter int CW   = CW_DEF,
  parameter int SYNC = 2,
  parameter bit INV  = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    ph,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          moved,
  output logic          illegal
);
  logic [SYNC-1:0][1:0] sync_q, sync_d;
  logic [1:0]           prev_q, prev_d, cur;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 fwd, rev, up, dn;

  assign cur = sync_q[SYNC-1];

  always_comb begin
    sync_d[0] = ph;
    for (int i = 1; i < SYNC; i++) sync_d[i] = sync_q[i-1];
    prev_d  = cur;
    // fwd_next never maps a phase to itself, so "no change" is neither
    fwd     = (cur == fwd_next(prev_q));
    rev     = (prev_q == fwd_next(cur));
    illegal = (cur != prev_q) && !fwd && !rev;
    moved   = fwd | rev;
    up      = INV ? rev : fwd;
    dn      = INV ? fwd : rev;
    cnt_d   = cnt_q;
    if (clr)     cnt_d = '0;
    else if (up) cnt_d = cnt_q + CW'(1);
    else if (dn) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/jtframe_dial_dec.sv
// Two-axis quadrature dial decoder with a coherent byte-read CPU port.
//   clk, rst_n      clock, async active-low reset
//   dial_x, dial_y  {B,A} phases per axis
//   clr_x, clr_y    synchronous live-counter clears
//   bus             CPU read port (cs, xn_y, uln -> dout, cf)
//   err             one-cycle pulse on an illegal transition on either axis
module jtframe_dial_dec
  import jtframe_dial_dec_pkg::*;
#(
  parameter int CW   = CW_DEF,
  parameter int SYNC = 2,
  parameter int INVX = 0,
  parameter int INVY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        dial_x,
  input  logic [1:0]        dial_y,
  input  logic              clr_x,
  input  logic              clr_y,
  jtframe_dial_dec_if.slave bus,
  output logic              err
);
  localparam logic [1:0] INV = {INVY != 0, INVX != 0};

  logic [1:0][1:0]    dial;
  logic [1:0]         clr, moved, illegal;
  logic [1:0][CW-1:0] cnt, snap_q, snap_d;
  logic [CW-1:0]      src;
  logic [7:0]         lo, hi, dout_q, dout_d;
  logic               cs_l_q, cs_rise, cs_fall, cf_q, cf_d, err_q, err_d;

  assign dial = {dial_y, dial_x};
  assign clr  = {clr_y, clr_x};

  for (genvar g = 0; g < 2; g++) begin : g_axis
    jtframe_dial_axis #(.CW(CW), .SYNC(SYNC), .INV(INV[g])) u_axis (
      .clk     (clk),
      .rst_n   (rst_n),
      .ph      (dial[g]),
      .clr     (clr[g]),
      .cnt     (cnt[g]),
      .moved   (moved[g]),
      .illegal (illegal[g])
    );
  end

  always_comb begin
    cs_rise = bus.cs & ~cs_l_q;
    cs_fall = ~bus.cs & cs_l_q;
    snap_d  = cs_rise ? cnt : snap_q;
    // on the rising cycle read straight from the value being captured so
    // data is valid on the very next edge
    src     = snap_d[bus.xn_y];
    lo      = src[7:0];
    hi      = 8'($signed(src[CW-1:8]));
    dout_d  = dout_q;
    if (bus.cs) dout_d = (byte_sel_e'(bus.uln) == BYTE_HI) ? hi : lo;
    // a count in the clearing cycle wins
    cf_d    = (|moved) | (cf_q & ~cs_fall);
    err_d   = |illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // cs_l starts high so a cs held through reset release is not an edge
      cs_l_q <= 1'b1;
      snap_q <= '0;
      dout_q <= '0;
      cf_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cs_l_q <= bus.cs;
      snap_q <= snap_d;
      dout_q <= dout_d;
      cf_q   <= cf_d;
      err_q  <= err_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.cf   = cf_q;
  assign err      = err_q;
endmodule

// File: tb/tb_jtframe_dial_dec.sv
module tb_jtframe_dial_dec;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] dial_x = 2'd0, dial_y = 2'd0;
  logic       clr_x = 1'b0, clr_y = 1'b0, clr_x_i = 1'b0;
  logic       err, ierr;
  int         total = 0, bad = 0, err_cnt = 0;
  logic [7:0] lo, hi, ilo, ihi;

  jtframe_dial_dec_if bus ();
  jtframe_dial_dec_if ibus ();

  jtframe_dial_dec #(.CW(12), .SYNC(2), .INVX(0), .INVY(0)) dut (
    .clk(clk), .rst_n(rst_n), .dial_x(dial_x), .dial_y(dial_y),
    .clr_x(clr_x), .clr_y(clr_y), .bus(bus), .err(err));

  jtframe_dial_dec #(.CW(12), .SYNC(2), .INVX(1), .INVY(1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .dial_x(dial_x), .dial_y(dial_y),
    .clr_x(clr_x_i), .clr_y(clr_y), .bus(ibus), .err(ierr));

  always #5 clk = ~clk;
  always @(negedge clk) if (err) err_cnt++;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_bus(input logic cs, input logic ax, input logic ul);
    bus.cs = cs;  bus.xn_y = ax;  bus.uln = ul;
    ibus.cs = cs; ibus.xn_y = ax; ibus.uln = ul;
  endtask

  task automatic read_ax(input logic ax);
    @(negedge clk) set_bus(1'b1, ax, 1'b0);
    @(negedge clk) begin lo = bus.dout; ilo = ibus.dout; set_bus(1'b1, ax, 1'b1); end
    @(negedge clk) begin hi = bus.dout; ihi = ibus.dout; set_bus(1'b0, ax, 1'b0); end
    @(negedge clk);
  endtask

  task automatic step_x(input logic [1:0] p);
    @(negedge clk) dial_x = p;
    repeat (4) @(negedge clk);
  endtask

  task automatic step_y(input logic [1:0] p);
    @(negedge clk) dial_y = p;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    set_bus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_dout", {8'h0, bus.dout}, 16'h0);
    chk("rst_cf", {15'h0, bus.cf}, 16'h0);
    chk("rst_err", {15'h0, err}, 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    read_ax(1'b0);
    chk("rst_read_x", {hi, lo}, 16'h0000);
  endtask

  task automatic test_fwd_x;
    step_x(2'd1); step_x(2'd3); step_x(2'd2); step_x(2'd0);
    chk("fwd_cf", {15'h0, bus.cf}, 16'h1);
    read_ax(1'b0);
    chk("fwd_lo", {8'h0, lo}, 16'h04);
    chk("fwd_hi", {8'h0, hi}, 16'h00);
    chk("fwd_cf_clr", {15'h0, bus.cf}, 16'h0);
  endtask

  task automatic test_rev_y;
    step_y(2'd2); step_y(2'd3); step_y(2'd1); step_y(2'd0);
    read_ax(1'b1);
    chk("rev_y_lo", {8'h0, lo}, 16'hFC);
    chk("rev_y_hi", {8'h0, hi}, 16'hFF);
  endtask

  task automatic test_wrap_inv;
    int e0;
    e0 = err_cnt;
    @(negedge clk) begin clr_x = 1'b1; clr_x_i = 1'b1; end
    @(negedge clk) begin clr_x = 1'b0; clr_x_i = 1'b0; end
    step_x(2'd2);                       // reverse: 0 -> 0xFFF
    read_ax(1'b0);
    chk("wrap_under", {hi, lo}, 16'hFFFF);
    @(negedge clk) clr_x_i = 1'b1;
    @(negedge clk) clr_x_i = 1'b0;
    step_x(2'd0);                       // forward: 0xFFF -> 0, inverted 0 -> 0xFFF
    read_ax(1'b0);
    chk("wrap_over", {hi, lo}, 16'h0000);
    chk("inv_fwd", {ihi, ilo}, 16'hFFFF);
    chk("wrap_no_err", 16'(err_cnt - e0), 16'd0);
  endtask

  task automatic test_illegal;
    int e0;
    e0 = err_cnt;
    step_x(2'd3);                       // 0 -> 3 both bits change
    chk("ill_err_pulse", 16'(err_cnt - e0), 16'd1);
    chk("ill_cf", {15'h0, bus.cf}, 16'h0);
    read_ax(1'b0);
    chk("ill_x_hold", {hi, lo}, 16'h0000);
  endtask

  task automatic test_snapshot;
    @(negedge clk) set_bus(1'b1, 1'b0, 1'b0);
    @(negedge clk) chk("snap_first", {8'h0, bus.dout}, 16'h00);
    step_x(2'd2); step_x(2'd0); step_x(2'd1);
    chk("snap_frozen", {8'h0, bus.dout}, 16'h00);
    chk("snap_cf_set", {15'h0, bus.cf}, 16'h1);
    @(negedge clk) set_bus(1'b0, 1'b0, 1'b0);
    @(negedge clk) chk("snap_cf_fall", {15'h0, bus.cf}, 16'h0);
    read_ax(1'b0);
    chk("snap_reread", {8'h0, lo}, 16'h03);
  endtask

  task automatic test_clr_count;
    chk("clr_cf_pre", {15'h0, bus.cf}, 16'h0);
    @(negedge clk) dial_x = 2'd3;       // forward step from 1
    @(posedge clk); @(posedge clk);
    @(negedge clk) clr_x = 1'b1;        // coincides with the decode cycle
    @(negedge clk) clr_x = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_cf", {15'h0, bus.cf}, 16'h1);
    read_ax(1'b0);
    chk("clr_x_zero", {hi, lo}, 16'h0000);
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk) set_bus(1'b1, 1'b1, 1'b0);
    @(negedge clk) chk("mid_y_lo", {8'h0, bus.dout}, 16'hFC);
    step_x(2'd2); step_x(2'd0);         // X: 0 -> 2, phase back at 0
    chk("mid_cf", {15'h0, bus.cf}, 16'h1);
    #2 rst_n = 1'b0;
    #1 begin
      chk("mid_rst_dout", {8'h0, bus.dout}, 16'h00);
      chk("mid_rst_cf", {15'h0, bus.cf}, 16'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_post_dout", {8'h0, bus.dout}, 16'h00);
    @(negedge clk) set_bus(1'b0, 1'b0, 1'b0);
    step_x(2'd1);
    read_ax(1'b0);
    chk("mid_resume", {hi, lo}, 16'h0001);
  endtask

  initial begin
    test_reset;
    test_fwd_x;
    test_rev_y;
    test_wrap_inv;
    test_illegal;
    test_snapshot;
    test_clr_count;
    test_reset_mid_read;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
